// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/issue controller for the 16-bit decoder.
// Resolves JMP/Bxx/HLT locally and issues ops 0-7 over valid/ready.
// Ports:
//   clk, reset (synchronous, active-low), start (leave IDLE/HALT)
//   mem_rd/mem_addr out, mem_valid/mem_data in : program memory read
//   wZa,wZb,wCa,wCb,wNa,wNb in                 : A/B datapath flags
//   wInstruction/issue_valid out, issue_ready in : decoder handshake
//   pc, halted out                              : status
module instr_sequencer #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_valid,
   input  logic [15:0]       mem_data,
   input  logic              wZa,
   input  logic              wZb,
   input  logic              wCa,
   input  logic              wCb,
   input  logic              wNa,
   input  logic              wNb,
   output logic [15:0]       wInstruction,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_SETTLE,
      S_HALT
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc_q, pc_nxt, pc_inc;
   logic [15:0]       ir_q, ir_nxt;
   logic [15:0]       winstr_q, winstr_nxt;
   logic [3:0]        op;
   logic [ADDR_W-1:0] tgt;
   logic              is_hlt, is_br, is_dp;
   logic              take;

   assign op     = ir_q[15:12];
   assign tgt    = ir_q[ADDR_W-1:0];
   assign pc_inc = pc_q + ADDR_W'(1);

   // ops 8..E redirect the pc, F halts, 0..7 go to the datapath
   assign is_hlt = (op == 4'hF);
   assign is_br  = op[3] & ~is_hlt;
   assign is_dp  = ~op[3];

   always_comb begin
      take = 1'b0;
      case (op)
         4'h8:    take = 1'b1;
         4'h9:    take = wZa;
         4'hA:    take = wZb;
         4'hB:    take = wCa;
         4'hC:    take = wCb;
         4'hD:    take = wNa;
         4'hE:    take = wNb;
         default: take = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc_q;
      ir_nxt     = ir_q;
      winstr_nxt = winstr_q;
      case (state)
         S_IDLE, S_HALT: begin
            if (start) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (mem_valid) begin
               ir_nxt    = mem_data;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            unique case (1'b1)
               is_hlt: state_nxt = S_HALT;
               is_br: begin
                  pc_nxt    = take ? tgt : pc_inc;
                  state_nxt = S_FETCH;
               end
               is_dp: begin
                  winstr_nxt = ir_q;
                  state_nxt  = S_ISSUE;
               end
            endcase
         end
         S_ISSUE: begin
            if (issue_ready) begin
               pc_nxt    = pc_inc;
               state_nxt = S_SETTLE;
            end
         end
         // one bubble so the datapath flags reflect the issued op
         S_SETTLE: state_nxt = S_FETCH;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         winstr_q <= '0;
      end else begin
         state    <= state_nxt;
         pc_q     <= pc_nxt;
         ir_q     <= ir_nxt;
         winstr_q <= winstr_nxt;
      end
   end

   assign mem_rd       = (state == S_FETCH);
   assign mem_addr     = pc_q;
   assign issue_valid  = (state == S_ISSUE);
   assign wInstruction = winstr_q;
   assign pc           = pc_q;
   assign halted       = (state == S_HALT);

endmodule
